// File: rtl/mips_state_sequencer.sv
// Multicycle instruction sequencer for the MIPS core: walks each instruction through
// fetch/decode/execute/memory/write-back, stalls on memory or mul/div, halts, counts retires.
//
// state         | meaning
// --------------+---------------------------------------------------------------
// S_FETCH       | instruction read on Avalon, held while waitrequest
// S_DECODE      | IR decode, always one cycle
// S_EXECUTE     | ALU op; mul/div holds here while alu_busy
// S_MEM         | load/store access (held on waitrequest); final cycle for store/other
// S_WRITE_BACK  | load data written to register file; final cycle for loads
// S_HALTED      | absorbing, left only through reset
module mips_state_sequencer #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          func_code,
  input  logic                waitrequest,
  input  logic                alu_busy,
  input  logic                pc_zero,
  output logic [2:0]          state,
  output logic                active,
  output logic                stall,
  output logic                instr_retired,
  output logic [RETIRE_W-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_FETCH      = 3'b000,
    S_DECODE     = 3'b001,
    S_EXECUTE    = 3'b010,
    S_MEM        = 3'b011,
    S_WRITE_BACK = 3'b100,
    S_HALTED     = 3'b101
  } state_e;

  state_e              state_q, state_d;
  logic                active_q, active_d;
  logic [RETIRE_W-1:0] count_q, count_d;
  logic                is_load, is_store, is_muldiv;

  // Loads occupy 100000..100110; 100111 is unassigned and falls through as "other".
  assign is_load   = (opcode[5:3] == 3'b100) && (opcode[2:0] != 3'b111);
  assign is_store  = (opcode == 6'b101000) || (opcode == 6'b101001) || (opcode == 6'b101011);
  assign is_muldiv = (opcode == 6'b000000) && (func_code[5:2] == 4'b0110);

  always_comb begin
    state_d       = state_q;
    stall         = 1'b0;
    instr_retired = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (waitrequest) stall   = 1'b1;
        else             state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (is_muldiv && alu_busy) stall   = 1'b1;
        else                       state_d = S_MEM;
      end
      S_MEM: begin
        if ((is_load || is_store) && waitrequest) stall         = 1'b1;
        else if (is_load)                         state_d       = S_WRITE_BACK;
        else                                      instr_retired = 1'b1;
      end
      S_WRITE_BACK: instr_retired = 1'b1;
      S_HALTED:     state_d       = S_HALTED;
      default:      state_d       = S_FETCH;
    endcase
    if (instr_retired) state_d = pc_zero ? S_HALTED : S_FETCH;
    active_d = (state_d != S_HALTED);
    count_d  = count_q + RETIRE_W'(instr_retired);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      active_q <= 1'b1;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      count_q  <= count_d;
    end
  end

  assign state         = state_q;
  assign active        = active_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_mips_state_sequencer.sv
// Randomized bench for mips_state_sequencer: instructions are expanded into per-cycle
// expectations from their class and stall counts, and a negedge process compares every cycle.
module tb_mips_state_sequencer;

  localparam int C_OTHER = 0, C_LOAD = 1, C_STORE = 2, C_MULDIV = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = '0, func_code = '0;
  logic        waitrequest = 1'b0, alu_busy = 1'b0, pc_zero = 1'b0;

  logic [2:0]  state_32, state_4;
  logic        active_32, active_4, stall_32, stall_4, ret_32, ret_4;
  logic [31:0] cnt_32;
  logic [3:0]  cnt_4;

  mips_state_sequencer #(.RETIRE_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func_code(func_code),
    .waitrequest(waitrequest), .alu_busy(alu_busy), .pc_zero(pc_zero),
    .state(state_32), .active(active_32), .stall(stall_32),
    .instr_retired(ret_32), .retired_count(cnt_32));

  mips_state_sequencer #(.RETIRE_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func_code(func_code),
    .waitrequest(waitrequest), .alu_busy(alu_busy), .pc_zero(pc_zero),
    .state(state_4), .active(active_4), .stall(stall_4),
    .instr_retired(ret_4), .retired_count(cnt_4));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc_n = 0, stall_seen = 0, exec_seen = 0, wb_seen = 0;
  logic        chk_en = 1'b0;
  logic [2:0]  e_state;
  logic        e_stall, e_ret, e_active = 1'b1;
  logic [31:0] e_count32 = '0;
  logic [3:0]  e_count4 = '0;
  logic        quiet = 1'b1, force_busy = 1'b0;

  logic [5:0]  load_tbl [7];
  logic [5:0]  store_tbl [3];
  logic [11:0] other_tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("state",     32'(state_32), 32'(e_state));
      check("state_w4",  32'(state_4),  32'(e_state));
      check("stall",     32'(stall_32), 32'(e_stall));
      check("stall_w4",  32'(stall_4),  32'(e_stall));
      check("retired",   32'(ret_32),   32'(e_ret));
      check("active",    32'(active_32), 32'(e_active));
      check("active_w4", 32'(active_4),  32'(e_active));
      check("count32",   cnt_32,         e_count32);
      check("count4",    32'(cnt_4),     32'(e_count4));
      if (stall_32) stall_seen++;
      if (state_32 == 3'b010) exec_seen++;
      if (state_32 == 3'b100) wb_seen++;
    end
  end

  function automatic logic dc();
    return quiet ? 1'b0 : 1'($urandom_range(0, 1));
  endfunction

  function automatic logic dcb();
    return force_busy ? 1'b1 : dc();
  endfunction

  // One clock cycle: drive inputs, publish the expected outputs, advance the model.
  task automatic cyc(input logic [2:0] st, input logic stl, input logic ret,
                     input logic wr, input logic busy, input logic pz);
    waitrequest = wr; alu_busy = busy; pc_zero = pz;
    e_state = st; e_stall = stl; e_ret = ret; chk_en = 1'b1;
    @(posedge clk); #1;
    cyc_n++;
    if (ret) begin
      e_count32++;
      e_count4++;
      if (pz) e_active = 1'b0;
    end
  endtask

  task automatic do_instr(input int cls, input logic [5:0] op, input logic [5:0] fn,
                          input int fw, input int mw, input int bw, input logic pzf);
    opcode = op; func_code = fn;
    for (int i = 0; i < fw; i++) cyc(3'b000, 1'b1, 1'b0, 1'b1, dcb(), dc());
    cyc(3'b000, 1'b0, 1'b0, 1'b0, dcb(), dc());
    cyc(3'b001, 1'b0, 1'b0, dc(), dcb(), dc());
    if (cls == C_MULDIV) begin
      for (int i = 0; i < bw; i++) cyc(3'b010, 1'b1, 1'b0, dc(), 1'b1, dc());
      cyc(3'b010, 1'b0, 1'b0, dc(), 1'b0, dc());
    end else begin
      cyc(3'b010, 1'b0, 1'b0, dc(), dcb(), dc());
    end
    if (cls == C_LOAD || cls == C_STORE) begin
      for (int i = 0; i < mw; i++) cyc(3'b011, 1'b1, 1'b0, 1'b1, dcb(), dc());
      if (cls == C_LOAD) begin
        cyc(3'b011, 1'b0, 1'b0, 1'b0, dcb(), dc());
        cyc(3'b100, 1'b0, 1'b1, dc(), dcb(), pzf);
      end else begin
        cyc(3'b011, 1'b0, 1'b1, 1'b0, dcb(), pzf);
      end
    end else begin
      cyc(3'b011, 1'b0, 1'b1, dc(), dcb(), pzf);
    end
  endtask

  task automatic reset_dut();
    chk_en = 1'b0;
    rst_n = 1'b0;
    waitrequest = 1'b0; alu_busy = 1'b0; pc_zero = 1'b0;
    e_count32 = '0; e_count4 = '0; e_active = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("reset_state",  32'(state_32),  32'd0);
    check("reset_active", 32'(active_32), 32'd1);
    check("reset_count",  cnt_32,         32'd0);
  endtask

  task automatic clr_obs();
    cyc_n = 0; stall_seen = 0; exec_seen = 0; wb_seen = 0;
  endtask

  initial begin
    int cls, fw, mw, bw;
    logic [5:0] op, fn;
    logic pzf;

    load_tbl  = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110};
    store_tbl = '{6'b101000, 6'b101001, 6'b101011};
    other_tbl = '{{6'b000000, 6'b100001}, {6'b000000, 6'b011100}, {6'b001001, 6'b011010},
                  {6'b000100, 6'b000000}, {6'b100111, 6'b011000}, {6'b101010, 6'b000000},
                  {6'b101110, 6'b111111}, {6'b111111, 6'b011011}};

    // ADDU stream: 3 instructions of 4 cycles each.
    reset_dut();
    clr_obs();
    repeat (3) do_instr(C_OTHER, 6'b000000, 6'b100001, 0, 0, 0, 1'b0);
    check("addu_count", cnt_32, 32'd3);
    check("addu_cycles", 32'(cyc_n), 32'd12);
    check("addu_no_wb", 32'(wb_seen), 32'd0);

    // LW with 2 fetch waits and 3 memory waits.
    clr_obs();
    do_instr(C_LOAD, 6'b100011, 6'b000000, 2, 3, 0, 1'b0);
    check("lw_cycles", 32'(cyc_n), 32'd10);
    check("lw_stalls", 32'(stall_seen), 32'd5);
    check("lw_wb_once", 32'(wb_seen), 32'd1);

    // DIV with 4 busy cycles, then ADDU with alu_busy forced high.
    clr_obs();
    do_instr(C_MULDIV, 6'b000000, 6'b011010, 0, 0, 4, 1'b0);
    check("div_exec", 32'(exec_seen), 32'd5);
    check("div_stalls", 32'(stall_seen), 32'd4);
    clr_obs();
    force_busy = 1'b1;
    do_instr(C_OTHER, 6'b000000, 6'b100001, 0, 0, 0, 1'b0);
    force_busy = 1'b0;
    check("addu_busy_exec", 32'(exec_seen), 32'd1);
    check("addu_busy_stalls", 32'(stall_seen), 32'd0);

    // Halt: SW retires with pc_zero high, then waitrequest toggles.
    reset_dut();
    do_instr(C_STORE, 6'b101011, 6'b000000, 0, 1, 0, 1'b1);
    check("halt_state", 32'(state_32), 32'd5);
    check("halt_active", 32'(active_32), 32'd0);
    check("halt_count", cnt_32, 32'd1);
    for (int i = 0; i < 6; i++) cyc(3'b101, 1'b0, 1'b0, 1'(i), 1'b1, 1'b1);
    check("halt_hold_state", 32'(state_32), 32'd5);
    check("halt_hold_count", cnt_32, 32'd1);

    // Asynchronous reset during the memory phase of a LW.
    reset_dut();
    do_instr(C_OTHER, 6'b000000, 6'b100001, 0, 0, 0, 1'b0);
    opcode = 6'b100011;
    cyc(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b0;
    waitrequest = 1'b1;
    #2;
    check("mid_pre_state", 32'(state_32), 32'd3);
    check("mid_pre_count", cnt_32, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", 32'(state_32), 32'd0);
    check("mid_rst_count", cnt_32, 32'd0);
    check("mid_rst_active", 32'(active_32), 32'd1);
    reset_dut();

    // Wrap of the 4-bit counter after 16 retires.
    repeat (16) do_instr(C_OTHER, 6'b000000, 6'b100001, 0, 0, 0, 1'b0);
    check("wrap_count4", 32'(cnt_4), 32'd0);
    check("wrap_count32", cnt_32, 32'd16);

    // Random instruction stream with occasional halts.
    quiet = 1'b0;
    for (int n = 0; n < 400; n++) begin
      cls = $urandom_range(0, 3);
      fn  = 6'($urandom);
      case (cls)
        C_LOAD:   op = load_tbl[$urandom_range(0, 6)];
        C_STORE:  op = store_tbl[$urandom_range(0, 2)];
        C_MULDIV: begin op = 6'b000000; fn = {4'b0110, 2'($urandom_range(0, 3))}; end
        default:  {op, fn} = other_tbl[$urandom_range(0, 7)];
      endcase
      fw  = $urandom_range(0, 3);
      mw  = $urandom_range(0, 3);
      bw  = $urandom_range(0, 4);
      pzf = ($urandom_range(0, 24) == 0);
      do_instr(cls, op, fn, fw, mw, bw, pzf);
      if (pzf) begin
        repeat (3) cyc(3'b101, 1'b0, 1'b0, dc(), dc(), dc());
        reset_dut();
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_state_sequencer.md
# mips_state_sequencer

Multicycle state register and next-state logic for the MIPS CPU core. Produces the 3-bit `state` consumed by `control_signal_simplified`, sequencing each instruction through FETCH, DECODE, EXECUTE, MEMORY_ACCESS and WRITE_BACK. It stalls on Avalon `waitrequest` during memory states and on a busy multiply/divide unit during EXECUTE. It also detects the halt condition and counts retired instructions.

## Interface
- `RETIRE_W`, 32: width of retired-instruction counter.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input 6: IR[31:26] of the current instruction. Valid from DECODE onward.
- `func_code` input 6: IR[5:0]. Valid from DECODE onward.
- `waitrequest` input 1: Avalon memory stall. High means the current read/write has not completed.
- `alu_busy` input 1: high while a MULT/MULTU/DIV/DIVU operation is still computing.
- `pc_zero` input 1: high when the PC register holds 0x00000000.
- `state` output 3: FETCH_INSTR=000, DECODE=001, EXECUTE=010, MEMORY_ACCESS=011, WRITE_BACK=100, HALTED=101.
- `active` output 1: high until the CPU halts.
- `stall` output 1: high in any cycle where `state` is held because of `waitrequest` or `alu_busy`.
- `instr_retired` output 1: one-cycle pulse in the final cycle of each instruction.
- `retired_count` output RETIRE_W: number of instructions retired since reset.

## Operation
- **Instruction classes**, decoded from `opcode`:
  - Load: LB 100000, LH 100001, LWL 100010, LW 100011, LBU 100100, LHU 100101, LWR 100110.
  - Store: SB 101000, SH 101001, SW 101011.
  - Muldiv: `opcode`=0 and `func_code` is 011000, 011001, 011010 or 011011.
  - All other encodings, including unknown ones, are "other".
- **FETCH_INSTR**:
  - Stay while `waitrequest`=1.
  - Otherwise go to DECODE.
- **DECODE**: always go to EXECUTE after one cycle.
- **EXECUTE**:
  - Muldiv: stay while `alu_busy`=1.
  - Otherwise go to MEMORY_ACCESS.
  - `alu_busy` is ignored for non-muldiv instructions.
- **MEMORY_ACCESS**:
  - Load/store: stay while `waitrequest`=1.
  - Load: on completion, go to WRITE_BACK.
  - Store/other: this is the final cycle (ALU results are written here).
- **WRITE_BACK**: final cycle for loads.
- **Final cycle** (the cycle in which the instruction completes):
  - `instr_retired`=1.
  - `retired_count` increments on the next edge, wrapping modulo 2^RETIRE_W.
  - Next state is HALTED if `pc_zero`=1 in that cycle, otherwise FETCH_INSTR.
- **HALTED**: absorbing state.
  - `active`=0, `stall`=0, `instr_retired`=0.
  - All inputs are ignored; only reset leaves it.
- **`stall` definition**: combinational.
  - (FETCH_INSTR & `waitrequest`) | (MEMORY_ACCESS & load/store & `waitrequest`) | (EXECUTE & muldiv & `alu_busy`).
- **`active`**: registered, cleared on the edge entering HALTED.
- **Illegal state codes** (110, 111) go to FETCH_INSTR on the next edge, without retiring.

## Timing
- **Reset values**:
  - `state`=FETCH_INSTR, `active`=1, `retired_count`=0.
  - `stall` and `instr_retired` follow combinationally from the reset state and inputs.
- **Reset assertion** takes effect immediately, mid-instruction or while HALTED; no partial retire is counted.
- **Minimum instruction latency** with no stalls:
  - Other/store: 4 cycles.
  - Load: 5 cycles.
- Each `waitrequest`/`alu_busy` cycle adds exactly one cycle.
- **Outputs**:
  - `state`, `active` and `retired_count` are registered.
  - `stall` and `instr_retired` are combinational from `state` and inputs.
- `pc_zero` is sampled only in the final cycle. Assertion in any other cycle has no effect.
- **Simultaneous final cycle and `pc_zero`**: the instruction is still counted. `retired_count` increments on the same edge that enters HALTED.
- **Counter wrap**: at all-ones, the next retire gives 0; no flag is raised.

## Test plan
- **ADDU stream**: reset release, `opcode`=0, `func_code`=100001, `waitrequest`=0, `pc_zero`=0 → `state` sequence 000,001,010,011,000.
  - `instr_retired` high in the 011 cycle; `retired_count`=3 after 12 cycles.
- **LW with memory stalls**: `opcode`=100011, `waitrequest` high 2 cycles in FETCH and 3 cycles in MEMORY_ACCESS → 10-cycle instruction.
  - `stall` high for exactly 5 cycles; WRITE_BACK visited once.
- **DIV with busy ALU**: `func_code`=011010, `alu_busy` high 4 cycles → EXECUTE lasts 5 cycles, `stall`=1 for 4 of them.
  - Same `alu_busy` with ADDU → no stall.
- **Halt**: SW retires with `pc_zero`=1 → `state`=101, `active`=0, `retired_count`=1.
  - `waitrequest` toggling afterwards changes nothing.
- **Reset mid-instruction**: `rst_n` low asynchronously during MEMORY_ACCESS of LW → `state`=000 and `retired_count`=0 immediately, before the next edge.
- **Wrap**: RETIRE_W=4, retire 16 ADDU → `retired_count` returns to 0.
